// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone classic slave: FSM states, response codes,
// bus widths and the base-address decode.
package wb_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_ACK  = 2'd1,
        RSP_ERR  = 2'd2,
        RSP_RTY  = 2'd3
    } wb_rsp_e;

    // Only the bits above the word index and byte offset take part in the decode.
    function automatic logic addr_match(input logic [WB_DW-1:0] adr,
                                        input logic [WB_DW-1:0] base,
                                        input int aw);
        return (adr >> (aw + 2)) == (base >> (aw + 2));
    endfunction

endpackage

// File: rtl/wb_slave_regfile.sv
// 2**AW x 32 register file with per-byte write enables, synchronous clear
// and an asynchronous (combinational) read port.
module wb_slave_regfile
    import wb_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [WB_DW-1:0]    wdata,
    input  logic [WB_SELW-1:0]  wsel,
    input  logic [AW-1:0]       raddr,
    output logic [WB_DW-1:0]    rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [WB_DW-1:0]   mem_reg [DEPTH];
    logic [WB_SELW-1:0] lane_we;

    genvar gi;
    generate
        for (gi = 0; gi < WB_SELW; gi++) begin : g_lane
            assign lane_we[gi] = we & wsel[gi];
        end
    endgenerate

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int b = 0; b < WB_SELW; b++) begin
                if (lane_we[b]) begin
                    mem_reg[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/wb_slave.sv
// Wishbone classic slave: fixed wait states, then one registered ACK/ERR/RTY
// strobe; writes and read capture happen at the edge that enters RESP.
module wb_slave
    import wb_pkg::*;
#(
    parameter int               AW          = 4,
    parameter logic [WB_DW-1:0] BASE        = 32'h0000_0000,
    parameter int               WAIT_STATES = 1
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic [WB_DW-1:0]    ADR_I,
    input  logic [WB_DW-1:0]    DAT_I,
    output logic [WB_DW-1:0]    DAT_O,
    input  logic [WB_SELW-1:0]  SEL_I,
    input  logic                CYC_I,
    input  logic                STB_I,
    input  logic                WE_I,
    input  logic [3:0]          TAG_I,
    output logic [3:0]          TAG_O,
    input  logic                BUSY_I,
    output logic                ACK_O,
    output logic                ERR_O,
    output logic                RTY_O
);

    localparam bit         WS_ZERO = (WAIT_STATES == 0);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    wb_state_e          state_reg;
    logic [3:0]         cnt_reg;
    logic               ack_reg;
    logic               err_reg;
    logic               rty_reg;
    logic [WB_DW-1:0]   dat_reg;
    logic [3:0]         tag_reg;

    logic               req;
    logic               in_range;
    logic               decide;
    logic               wr_en;
    wb_rsp_e            rsp_next;
    logic [WB_DW-1:0]   rd_data;

    assign req      = CYC_I & STB_I;
    assign in_range = addr_match(ADR_I, BASE, AW);

    // The decision edge is the one that moves the FSM into RESP.
    assign decide = req && ((state_reg == ST_IDLE && WS_ZERO) ||
                            (state_reg == ST_WAIT && cnt_reg == 4'd0));

    always_comb begin
        rsp_next = RSP_NONE;
        if (decide) begin
            if (!in_range) begin
                rsp_next = RSP_ERR;
            end else if (BUSY_I) begin
                rsp_next = RSP_RTY;
            end else begin
                rsp_next = RSP_ACK;
            end
        end
    end

    assign wr_en = (rsp_next == RSP_ACK) && WE_I;

    wb_slave_regfile #(
        .AW(AW)
    ) u_regfile (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .we    (wr_en),
        .waddr (ADR_I[AW+1:2]),
        .wdata (DAT_I),
        .wsel  (SEL_I),
        .raddr (ADR_I[AW+1:2]),
        .rdata (rd_data)
    );

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            rty_reg   <= 1'b0;
            dat_reg   <= '0;
            tag_reg   <= '0;
        end else begin
            ack_reg <= (rsp_next == RSP_ACK);
            err_reg <= (rsp_next == RSP_ERR);
            rty_reg <= (rsp_next == RSP_RTY);

            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        if (WS_ZERO) begin
                            state_reg <= ST_RESP;
                        end else begin
                            state_reg <= ST_WAIT;
                            cnt_reg   <= WS_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state_reg <= ST_IDLE;
                    end else if (cnt_reg == 4'd0) begin
                        state_reg <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                // A request still present here is ignored; it restarts from IDLE.
                ST_RESP: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase

            if (decide) begin
                tag_reg <= TAG_I;
                if (rsp_next == RSP_ERR) begin
                    dat_reg <= '0;
                end else if (rsp_next == RSP_ACK && !WE_I) begin
                    dat_reg <= rd_data;
                end
            end
        end
    end

    assign ACK_O = ack_reg;
    assign ERR_O = err_reg;
    assign RTY_O = rty_reg;
    assign DAT_O = dat_reg;
    assign TAG_O = tag_reg;

endmodule

// File: tb/tb_wb_slave.sv
// Self-checking bench for wb_slave: directed vector table, multi-cycle corner
// sequences and random transfers checked against a behavioural memory model.
module tb_wb_slave;

    localparam int R_NONE = 0;
    localparam int R_ACK  = 1;
    localparam int R_ERR  = 2;
    localparam int R_RTY  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  tag;
    logic        busy;

    logic [31:0] dat_o2, dat_o0;
    logic [3:0]  tag_o2, tag_o0;
    logic        ack2, err2, rty2;
    logic        ack0, err0, rty0;

    int checks   = 0;
    int failures = 0;
    int xfer_no  = 0;

    logic [31:0] mem_model [16];
    logic [31:0] dat_model;

    always #5 clk = ~clk;

    wb_slave #(.AW(4), .BASE(32'h0), .WAIT_STATES(2)) dut (
        .CLK_I(clk), .RST_I(rst), .ADR_I(adr), .DAT_I(dat_i), .DAT_O(dat_o2),
        .SEL_I(sel), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .TAG_I(tag),
        .TAG_O(tag_o2), .BUSY_I(busy), .ACK_O(ack2), .ERR_O(err2), .RTY_O(rty2)
    );

    wb_slave #(.AW(4), .BASE(32'h0), .WAIT_STATES(0)) dut_ws0 (
        .CLK_I(clk), .RST_I(rst), .ADR_I(adr), .DAT_I(dat_i), .DAT_O(dat_o0),
        .SEL_I(sel), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .TAG_I(tag),
        .TAG_O(tag_o0), .BUSY_I(busy), .ACK_O(ack0), .ERR_O(err0), .RTY_O(rty0)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [3:0]  tag;
        logic        busy;
        int          exp_rsp;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] strobes(input int which);
        return (which == 0) ? {ack0, err0, rty0} : {ack2, err2, rty2};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem_model[i] = '0;
        dat_model = '0;
    endtask

    // Behavioural view: decode, priority ERR > RTY > ACK, byte-merge on write.
    task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic w, input logic b,
                              output int rsp, output logic [31:0] dexp);
        int idx;
        idx = int'(a[5:2]);
        if (a[31:6] != 26'd0) begin
            rsp = R_ERR;
            dat_model = '0;
        end else if (b) begin
            rsp = R_RTY;
        end else begin
            rsp = R_ACK;
            if (w) begin
                for (int l = 0; l < 4; l++)
                    if (s[l]) mem_model[idx][8*l +: 8] = d[8*l +: 8];
            end else begin
                dat_model = mem_model[idx];
            end
        end
        dexp = dat_model;
    endtask

    task automatic xfer(input int which, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic w, input logic [3:0] t,
                        input logic b, input logic hold,
                        output int rsp, output logic [31:0] dout,
                        output logic [3:0] tout, output int lat);
        logic [2:0] st;
        @(negedge clk);
        adr = a; dat_i = d; sel = s; we = w; tag = t; busy = b;
        cyc = 1'b1; stb = 1'b1;
        lat = 0;
        st  = 3'b000;
        while (lat < 20 && st == 3'b000) begin
            @(posedge clk); #1;
            lat++;
            st = strobes(which);
        end
        chk("strobe_exclusive", 32'($countones(st) <= 1), 32'd1);
        rsp  = st[2] ? R_ACK : st[1] ? R_ERR : st[0] ? R_RTY : R_NONE;
        dout = (which == 0) ? dat_o0 : dat_o2;
        tout = (which == 0) ? tag_o0 : tag_o2;
        stb = 1'b0;
        if (!hold) cyc = 1'b0;
        @(posedge clk); #1;
        chk("one_cycle_strobe", 32'(strobes(which)), 32'd0);
    endtask

    task automatic run_check(input string name, input int which,
                             input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic w, input logic [3:0] t, input logic b, input logic hold,
                             input int exp_rsp, input logic [31:0] exp_dat);
        int rsp, lat;
        logic [31:0] dout;
        logic [3:0]  tout;
        xfer(which, a, d, s, w, t, b, hold, rsp, dout, tout, lat);
        xfer_no++;
        $display("xfer %0d %s dut_ws=%0d adr=%h we=%0b sel=%b busy=%0b rsp=%0d dat_o=%h tag_o=%h lat=%0d",
                 xfer_no, name, (which == 0) ? 0 : 2, a, w, s, b, rsp, dout, tout, lat);
        chk({name, "_rsp"}, 32'(rsp), 32'(exp_rsp));
        chk({name, "_lat"}, 32'(lat), (which == 0) ? 32'd1 : 32'd3);
        chk({name, "_dat"}, dout, exp_dat);
        chk({name, "_tag"}, 32'(tout), 32'(t));
    endtask

    task automatic model_check(input string name, input int which,
                               input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic w, input logic [3:0] t, input logic b, input logic hold);
        int ersp;
        logic [31:0] edat;
        model_step(a, d, s, w, b, ersp, edat);
        run_check(name, which, a, d, s, w, t, b, hold, ersp, edat);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int erspd;
        logic [31:0] edatd;
        logic [31:0] ra;

        rst = 1'b1; adr = '0; dat_i = '0; sel = '0; cyc = 1'b0; stb = 1'b0;
        we = 1'b0; tag = '0; busy = 1'b0;

        tbl[0]  = '{32'h08, 32'hDEADBEEF, 4'hF, 1'b1, 4'h3, 1'b0, R_ACK, 32'h0};
        tbl[1]  = '{32'h08, 32'h0,        4'hF, 1'b0, 4'h5, 1'b0, R_ACK, 32'hDEADBEEF};
        tbl[2]  = '{32'h0B, 32'h0,        4'h0, 1'b0, 4'h6, 1'b0, R_ACK, 32'hDEADBEEF};
        tbl[3]  = '{32'h04, 32'h11223344, 4'hF, 1'b1, 4'h1, 1'b0, R_ACK, 32'hDEADBEEF};
        tbl[4]  = '{32'h04, 32'hAABBCCDD, 4'h5, 1'b1, 4'h2, 1'b0, R_ACK, 32'hDEADBEEF};
        tbl[5]  = '{32'h04, 32'h0,        4'hF, 1'b0, 4'h7, 1'b0, R_ACK, 32'h11BB33DD};
        tbl[6]  = '{32'h04, 32'hFFFFFFFF, 4'h0, 1'b1, 4'h8, 1'b0, R_ACK, 32'h11BB33DD};
        tbl[7]  = '{32'h04, 32'h0,        4'hF, 1'b0, 4'h9, 1'b0, R_ACK, 32'h11BB33DD};
        tbl[8]  = '{32'h40, 32'h0,        4'hF, 1'b0, 4'hA, 1'b0, R_ERR, 32'h0};
        tbl[9]  = '{32'h80000000, 32'h5,  4'hF, 1'b1, 4'hB, 1'b0, R_ERR, 32'h0};
        tbl[10] = '{32'h0C, 32'h12345678, 4'hF, 1'b1, 4'hC, 1'b1, R_RTY, 32'h0};
        tbl[11] = '{32'h0C, 32'h0,        4'hF, 1'b0, 4'hD, 1'b0, R_ACK, 32'h0};
        tbl[12] = '{32'h08, 32'h0,        4'hF, 1'b0, 4'hE, 1'b1, R_RTY, 32'h0};
        tbl[13] = '{32'h0C, 32'h12345678, 4'hF, 1'b1, 4'hF, 1'b0, R_ACK, 32'h0};
        tbl[14] = '{32'h0C, 32'h0,        4'h0, 1'b0, 4'h4, 1'b0, R_ACK, 32'h12345678};
        tbl[15] = '{32'h3C, 32'h0,        4'hF, 1'b0, 4'h2, 1'b0, R_ACK, 32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_strobes", 32'(strobes(2)), 32'd0);
        chk("reset_dat_o", dat_o2, 32'h0);
        chk("reset_tag_o", 32'(tag_o2), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            model_step(tbl[i].adr, tbl[i].dat, tbl[i].sel, tbl[i].we, tbl[i].busy, erspd, edatd);
            run_check($sformatf("tbl%0d", i), 2, tbl[i].adr, tbl[i].dat, tbl[i].sel,
                      tbl[i].we, tbl[i].tag, tbl[i].busy, 1'b0, tbl[i].exp_rsp, tbl[i].exp_dat);
        end

        // RMW / block with CYC held high throughout
        model_check("rmw_rd", 2, 32'h0, 32'h0, 4'hF, 1'b0, 4'h1, 1'b0, 1'b1);
        model_check("rmw_wr", 2, 32'h0, 32'hCAFEF00D, 4'hF, 1'b1, 4'h2, 1'b0, 1'b1);
        run_check("rmw_rd2", 2, 32'h0, 32'h0, 4'hF, 1'b0, 4'h3, 1'b0, 1'b1, R_ACK, 32'hCAFEF00D);
        chk("rmw_cyc_held", 32'(cyc), 32'd1);
        @(negedge clk);
        cyc = 1'b0;
        dat_model = 32'hCAFEF00D;

        // Abort: STB dropped one cycle into WAIT
        @(negedge clk);
        adr = 32'h10; dat_i = 32'h7; sel = 4'hF; we = 1'b1; busy = 1'b0; tag = 4'h6;
        cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_rsp", 32'(strobes(2)), 32'd0);
        end
        model_check("abort_rd", 2, 32'h10, 32'h0, 4'hF, 1'b0, 4'h5, 1'b0, 1'b0);

        // Reset in the middle of WAIT
        model_check("pre_rst_rd", 2, 32'h0, 32'h0, 4'hF, 1'b0, 4'h9, 1'b0, 1'b0);
        @(negedge clk);
        adr = 32'h14; dat_i = 32'h99; sel = 4'hF; we = 1'b1; tag = 4'hA;
        cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_strobes", 32'(strobes(2)), 32'd0);
        chk("rst_mid_dat_o", dat_o2, 32'h0);
        chk("rst_mid_tag_o", 32'(tag_o2), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0; stb = 1'b0; cyc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_idle", 32'(strobes(2)), 32'd0);
        end
        model_check("post_rst_rd0", 2, 32'h0, 32'h0, 4'hF, 1'b0, 4'h1, 1'b0, 1'b0);
        model_check("post_rst_rd14", 2, 32'h14, 32'h0, 4'hF, 1'b0, 4'h2, 1'b0, 1'b0);

        // Random transfers against the model
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) ra = $urandom() | 32'h40;
            else ra = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            model_check($sformatf("rnd%0d", i), 2, ra, $urandom(), 4'($urandom_range(0, 15)),
                        1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        1'($urandom_range(0, 5) == 0), 1'b0);
        end

        // Sweep every word: catches stray writes from ERR/RTY transfers
        for (int i = 0; i < 16; i++) begin
            model_check($sformatf("sweep%0d", i), 2, 32'(i * 4), 32'h0, 4'hF, 1'b0,
                        4'(i), 1'b0, 1'b0);
        end

        // Zero wait states, CYC held across read/write/read
        do_reset();
        model_check("ws0_rd", 0, 32'h0, 32'h0, 4'hF, 1'b0, 4'h1, 1'b0, 1'b1);
        model_check("ws0_wr", 0, 32'h0, 32'hCAFEF00D, 4'hF, 1'b1, 4'h2, 1'b0, 1'b1);
        run_check("ws0_rd2", 0, 32'h0, 32'h0, 4'hF, 1'b0, 4'h3, 1'b0, 1'b1, R_ACK, 32'hCAFEF00D);
        run_check("ws0_err", 0, 32'h40, 32'h0, 4'hF, 1'b0, 4'h4, 1'b0, 1'b0, R_ERR, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
